ram_2port_rd_checker: RTL and testbench
=======================================

// Module: ram_2port_rd_checker
// PURPOSE
//  Synthesizable read-side checker for the ram_2port simple dual-port RAM.
//  Sweeps every read address once, compares rd_data against the descending fill pattern, counts mismatches.
//  Sits on the RAM read port; both RAM ports run on wr_clk for on-board self-test; started by the write-side filler's done pulse.
// PARAMETERS
//  ADDR_WIDTH   5        RAM read address width; sweep covers 0 .. 2**ADDR_WIDTH-1
//  DATA_WIDTH   8        RAM read data width
//  INIT_VAL     all-1s   pattern seed; expected(a) = (INIT_VAL - a) mod 2**DATA_WIDTH
//  ERR_WIDTH    8        error counter width
// PORTS
//  wr_clk          in   1           clock; also clocks the RAM read port
//  tb_wr_rst       in   1           reset, asynchronous, active-high
//  start           in   1           1-cycle pulse; begins a sweep (ignored while busy)
//  rd_addr         out  ADDR_WIDTH  RAM read address
//  rd_en           out  1           high while an address is being issued
//  rd_data         in   DATA_WIDTH  RAM read data
//  busy            out  1           sweep in progress (READ or DRAIN)
//  done            out  1           level; set at sweep end, cleared by next accepted start
//  pass            out  1           done && err_cnt==0
//  err_cnt         out  ERR_WIDTH   mismatch count, saturating
//  first_err_addr  out  ADDR_WIDTH  address of the first mismatch in the sweep
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> IDLE. Async assert, deassert synchronous to wr_clk edge; mid-sweep reset aborts, no done.
//  FSM: IDLE -start-> READ; READ -last addr issued-> DRAIN; DRAIN -LAT cycles-> DONE; DONE -start-> READ.
//  Accepting start (IDLE or DONE) clears err_cnt, first_err_addr, done; rd_addr=0 on next cycle.
//  READ: rd_en=1, rd_addr increments by 1 each cycle, 0 .. 2**ADDR_WIDTH-1, no gaps, no wrap; exactly 2**ADDR_WIDTH cycles.
//  Read latency LAT=1: address issued at cycle N, rd_data sampled at N+1.
//  Compare pipe: LAT-deep shift of {valid=rd_en, addr}; when valid exits, compare rd_data vs INIT_VAL - addr (DATA_WIDTH truncation).
//  Mismatch: err_cnt += 1 unless all-ones (saturates, holds); first mismatch of the sweep latches first_err_addr.
//  DRAIN: rd_en=0, rd_addr holds last value; waits until final compare done (LAT cycles), then done=1 registered, busy=0.
//  busy=1 from cycle after accepted start through last DRAIN cycle.
//  start in READ/DRAIN: ignored, no effect on counters.
//  start coincident with final DRAIN cycle: ignored; done still asserts.
//  rd_data not compared while valid=0 (idle X on RAM output tolerated).
// CONFIGURATION
//  RAM_CHK_OUTREG_EN defined: LAT=2 (matches RAM OUTPUT_REG=1); compare pipe 2 deep, DRAIN 2 cycles.
//  RAM_CHK_OUTREG_EN undefined: LAT=1 (RAM OUTPUT_REG=0); compare pipe 1 deep, DRAIN 1 cycle.
//  Total sweep: 2**ADDR_WIDTH + LAT cycles start-accept to done.
// TESTING
//  1 Reset: tb_wr_rst=1 -> all outputs 0; release, idle 10 cycles -> rd_en=0, done=0.
//  2 Clean sweep: RAM filled with FF,FE..E0 at addr 0..31, start -> rd_addr 0..31 once; done after 33 cycles (34 with macro); pass=1, err_cnt=0.
//  3 Single fault: RAM addr 7 = 0x00 -> err_cnt=1, first_err_addr=7, pass=0.
//  4 Saturation: ERR_WIDTH=3, all 32 locations wrong -> err_cnt=7, holds 7.
//  5 Start rules: start pulses at READ cycles 5 and 20 -> ignored, sweep unchanged; start from DONE clears counters, reruns.
//  6 Mid-sweep reset at rd_addr=12 -> outputs 0 immediately, done never asserts; new start -> full clean sweep.

Source files
------------

// File: rtl/ram_2port_rd_checker.sv
// ---------------------------------------------------------------------------
// ram_2port_rd_checker
//
// Purpose:
//   Read-side self-test checker for the ram_2port simple dual-port RAM.
//   On an accepted start pulse it sweeps every read address exactly once.
//   It compares each returned word against the descending fill pattern
//   (INIT_VAL - addr) and counts mismatches in a saturating counter.
//   It also latches the address of the first mismatch.
//   Both RAM ports run on wr_clk, so read latency is a fixed cycle count.
//
// Configuration macro:
//   RAM_CHK_OUTREG_EN  defined   -> read latency 2 (RAM built with its output
//                                   register), 2-deep compare pipe, 2 DRAIN
//                                   cycles
//                      undefined -> read latency 1, 1-deep compare pipe,
//                                   1 DRAIN cycle
//
// Ports:
//   wr_clk          in   clock, also clocks the RAM read port
//   tb_wr_rst       in   asynchronous active-high reset; the surrounding
//                        logic releases it synchronously to wr_clk
//   start           in   1-cycle pulse, begins a sweep from IDLE or DONE
//   rd_addr         out  RAM read address
//   rd_en           out  high while an address is being issued
//   rd_data         in   RAM read data
//   busy            out  sweep in progress (READ or DRAIN)
//   done            out  level, set at sweep end, cleared by next accepted start
//   pass            out  done with zero mismatches
//   err_cnt         out  saturating mismatch count
//   first_err_addr  out  address of the first mismatch of the sweep
// ---------------------------------------------------------------------------
module ram_2port_rd_checker #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '1,
  parameter int                    ERR_WIDTH  = 8
) (
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

`ifdef RAM_CHK_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;
  localparam logic [1:0]            DRAIN_LAST = 2'(LAT - 1);
  localparam logic [ERR_WIDTH-1:0]  ERR_MAX    = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                            state_q, state_d;
  logic [ADDR_WIDTH-1:0]             rd_addr_q, rd_addr_d;
  logic [1:0]                        drain_cnt_q, drain_cnt_d;
  logic                              done_q, done_d;
  logic [ERR_WIDTH-1:0]              err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0]             first_err_q, first_err_d;

  // Compare pipe: tracks which issued address the current rd_data belongs to.
  logic [LAT-1:0]                    vld_q;
  logic [LAT-1:0][ADDR_WIDTH-1:0]    addr_pipe_q;

  logic                              start_acc;
  logic                              drain_last;
  logic                              cmp_vld;
  logic [ADDR_WIDTH-1:0]             cmp_addr;
  logic [DATA_WIDTH-1:0]             exp_data;
  logic                              mismatch;

  // Start is only honoured between sweeps; pulses during READ/DRAIN vanish.
  assign start_acc  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign drain_last = (state_q == S_DRAIN) && (drain_cnt_q == DRAIN_LAST);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start)                   state_d = S_READ;
      S_READ:         if (rd_addr_q == ADDR_LAST)  state_d = S_DRAIN;
      S_DRAIN:        if (drain_last)              state_d = S_DONE;
      default:                                     state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    rd_en = 1'b0;
    busy  = 1'b0;
    unique case (state_q)
      S_READ:  begin rd_en = 1'b1; busy = 1'b1; end
      S_DRAIN: busy = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------
  assign cmp_vld  = vld_q[LAT-1];
  assign cmp_addr = addr_pipe_q[LAT-1];
  assign exp_data = INIT_VAL - DATA_WIDTH'(cmp_addr);
  // Gated by cmp_vld so an undriven (X) RAM output between sweeps never counts.
  assign mismatch = cmp_vld && (rd_data != exp_data);

  always_comb begin
    rd_addr_d   = rd_addr_q;
    drain_cnt_d = 2'd0;
    done_d      = done_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;

    if (start_acc) begin
      rd_addr_d   = '0;
      done_d      = 1'b0;
      err_cnt_d   = '0;
      first_err_d = '0;
    end else begin
      // Address stops at the last location and holds through DRAIN and DONE.
      if ((state_q == S_READ) && (rd_addr_q != ADDR_LAST))
        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
      if (state_q == S_DRAIN)
        drain_cnt_d = drain_cnt_q + 2'd1;
      // The last compare lands on the same edge that sets done, so pass sees
      // the final count.
      if (drain_last)
        done_d = 1'b1;
      if (mismatch) begin
        if (err_cnt_q != ERR_MAX)
          err_cnt_d = err_cnt_q + ERR_WIDTH'(1);
        // A saturating counter never returns to zero, so zero means no
        // mismatch has been seen yet in this sweep.
        if (err_cnt_q == '0)
          first_err_d = cmp_addr;
      end
    end
  end

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      rd_addr_q   <= '0;
      drain_cnt_q <= 2'd0;
      done_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  // Compare pipe shift: stage 0 captures what was issued this cycle.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      vld_q       <= '0;
      addr_pipe_q <= '0;
    end else begin
      vld_q[0]       <= rd_en;
      addr_pipe_q[0] <= rd_addr_q;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i]       <= vld_q[i-1];
        addr_pipe_q[i] <= addr_pipe_q[i-1];
      end
    end
  end

  assign rd_addr        = rd_addr_q;
  assign done           = done_q;
  assign pass           = done_q && (err_cnt_q == '0);
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_ram_2port_rd_checker.sv
// ---------------------------------------------------------------------------
// tb_ram_2port_rd_checker
//
// Bench for ram_2port_rd_checker.
// A behavioural RAM read port drives rd_data. It has an optional output
// register, enabled by RAM_CHK_OUTREG_EN.
// Two checker instances share the RAM:
//   - the main instance uses ERR_WIDTH=8;
//   - a second instance uses ERR_WIDTH=3 to exercise saturation.
// The expected read-address sequence of each sweep is queued at start and
// popped as the DUT issues reads. Inputs change and outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_ram_2port_rd_checker;

`ifdef RAM_CHK_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH    = 32;
  localparam int DONE_CYC = DEPTH + LAT;   // intervals from accept to done

  logic       wr_clk = 1'b0;
  logic       tb_wr_rst;
  logic       start;
  logic [4:0] rd_addr, rd_addr_s;
  logic       rd_en, rd_en_s;
  logic [7:0] rd_data;
  logic       busy, done, pass;
  logic       busy_s, done_s, pass_s;
  logic [7:0] err_cnt;
  logic [2:0] err_cnt_s;
  logic [4:0] first_err_addr, first_err_addr_s;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  always #5 wr_clk = ~wr_clk;

  // ---------------- RAM read-port model ----------------
  logic [7:0] mem [DEPTH];
  logic [7:0] ram_q1, ram_q2;
  always @(posedge wr_clk) begin
    if (rd_en) ram_q1 <= mem[rd_addr];
    ram_q2 <= ram_q1;
  end
  assign rd_data = (LAT == 2) ? ram_q2 : ram_q1;

  ram_2port_rd_checker #(.ERR_WIDTH(8)) u_dut (
    .wr_clk         (wr_clk),
    .tb_wr_rst      (tb_wr_rst),
    .start          (start),
    .rd_addr        (rd_addr),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

  ram_2port_rd_checker #(.ERR_WIDTH(3)) u_dut_sat (
    .wr_clk         (wr_clk),
    .tb_wr_rst      (tb_wr_rst),
    .start          (start),
    .rd_addr        (rd_addr_s),
    .rd_en          (rd_en_s),
    .rd_data        (rd_data),
    .busy           (busy_s),
    .done           (done_s),
    .pass           (pass_s),
    .err_cnt        (err_cnt_s),
    .first_err_addr (first_err_addr_s)
  );

  // ---------------- helpers (stimulus only) ----------------
  task automatic fill_clean();
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'(8'hFF - a);
  endtask

  // Pulses start, then follows the sweep cycle by cycle. Extra start pulses
  // are driven in the intervals p0/p1/p2 (-1 = none).
  task automatic run_sweep(input string tag, input int p0, input int p1,
                           input int p2);
    int  done_cyc;
    int  e;
    bit  busy_bad;
    exp_q.delete();
    for (int a = 0; a < DEPTH; a++) exp_q.push_back(a);
    done_cyc = -1;
    busy_bad = 1'b0;
    @(negedge wr_clk); start = 1'b1;
    @(negedge wr_clk); start = 1'b0;
    total++;
    if (err_cnt !== 8'd0 || first_err_addr !== 5'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s accept_clear: err=%0d first=%0d done=%b want 0/0/0",
               tag, err_cnt, first_err_addr, done);
    end
    for (int c = 0; c < 200; c++) begin
      start = 1'b0;
      if (done === 1'b1) begin done_cyc = c; break; end
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (rd_en === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s extra_read: addr=%0d at cycle %0d", tag, rd_addr, c);
        end else begin
          e = exp_q.pop_front();
          if (rd_addr !== 5'(e)) begin
            bad++;
            $display("FAIL %s rd_addr: got %0d want %0d", tag, rd_addr, e);
          end
        end
      end
      if (c == p0 || c == p1 || c == p2) start = 1'b1;
      @(negedge wr_clk);
    end
    start = 1'b0;
    total++;
    if (done_cyc !== DONE_CYC) begin
      bad++;
      $display("FAIL %s done_latency: got %0d want %0d", tag, done_cyc, DONE_CYC);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s missing_reads: got %0d left want 0", tag, exp_q.size());
    end
    total++;
    if (busy_bad || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy: gap=%b at_done=%b want 0/0", tag, busy_bad, busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit bad_idle = 1'b0;
    tb_wr_rst = 1'b1;
    start     = 1'b0;
    repeat (3) @(negedge wr_clk);
    total++;
    if ({rd_addr, rd_en, busy, done, pass, err_cnt, first_err_addr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: addr=%0d en=%b busy=%b done=%b pass=%b err=%0d first=%0d want all 0",
               rd_addr, rd_en, busy, done, pass, err_cnt, first_err_addr);
    end
    tb_wr_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge wr_clk);
      if (rd_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad_idle = 1'b1;
    end
    total++;
    if (bad_idle) begin
      bad++;
      $display("FAIL reset_idle: en/done/busy went high, got %b want 0", bad_idle);
    end
  endtask

  task automatic test_clean_sweep();
    fill_clean();
    run_sweep("clean", -1, -1, -1);
    total++;
    if (pass !== 1'b1 || err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL clean_result: pass=%b err=%0d want 1/0", pass, err_cnt);
    end
    total++;
    if (err_cnt_s !== 3'd0 || pass_s !== 1'b1) begin
      bad++;
      $display("FAIL clean_sat_inst: pass=%b err=%0d want 1/0", pass_s, err_cnt_s);
    end
  endtask

  task automatic test_single_fault();
    fill_clean();
    mem[7] = 8'h00;
    run_sweep("fault7", -1, -1, -1);
    total++;
    if (err_cnt !== 8'd1 || first_err_addr !== 5'd7 || pass !== 1'b0) begin
      bad++;
      $display("FAIL fault7_result: err=%0d first=%0d pass=%b want 1/7/0",
               err_cnt, first_err_addr, pass);
    end
    repeat (5) @(negedge wr_clk);
    total++;
    if (done !== 1'b1 || err_cnt !== 8'd1) begin
      bad++;
      $display("FAIL fault7_hold: done=%b err=%0d want 1/1", done, err_cnt);
    end
  endtask

  task automatic test_saturation();
    for (int a = 0; a < DEPTH; a++) mem[a] = ~(8'(8'hFF - a));
    run_sweep("all_bad", -1, -1, -1);
    total++;
    if (err_cnt !== 8'd32 || first_err_addr !== 5'd0 || pass !== 1'b0) begin
      bad++;
      $display("FAIL all_bad_result: err=%0d first=%0d pass=%b want 32/0/0",
               err_cnt, first_err_addr, pass);
    end
    total++;
    if (err_cnt_s !== 3'd7 || pass_s !== 1'b0) begin
      bad++;
      $display("FAIL sat_count: err=%0d pass=%b want 7/0", err_cnt_s, pass_s);
    end
    repeat (5) @(negedge wr_clk);
    total++;
    if (err_cnt_s !== 3'd7 || done_s !== 1'b1) begin
      bad++;
      $display("FAIL sat_hold: err=%0d done=%b want 7/1", err_cnt_s, done_s);
    end
  endtask

  // Starts from DONE (left dirty by the saturation sweep). Pulses start twice
  // during READ and once in the final DRAIN cycle.
  task automatic test_start_rules();
    fill_clean();
    run_sweep("start_rules", 5, 20, DONE_CYC - 1);
    total++;
    if (pass !== 1'b1 || err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL start_rules_result: pass=%b err=%0d want 1/0", pass, err_cnt);
    end
    repeat (3) @(negedge wr_clk);
    total++;
    if (rd_en !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL late_start_ignored: en=%b done=%b busy=%b want 0/1/0",
               rd_en, done, busy);
    end
  endtask

  task automatic test_mid_reset();
    bit reached   = 1'b0;
    bit done_seen = 1'b0;
    fill_clean();
    @(negedge wr_clk); start = 1'b1;
    @(negedge wr_clk); start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rd_en === 1'b1 && rd_addr === 5'd12) begin reached = 1'b1; break; end
      @(negedge wr_clk);
    end
    total++;
    if (!reached) begin
      bad++;
      $display("FAIL mid_reset_reach: addr=%0d want 12", rd_addr);
    end
    #2 tb_wr_rst = 1'b1;
    #1;
    total++;
    if ({rd_addr, rd_en, busy, done, pass, err_cnt, first_err_addr} !== '0) begin
      bad++;
      $display("FAIL mid_reset_async: addr=%0d en=%b busy=%b done=%b want all 0",
               rd_addr, rd_en, busy, done);
    end
    @(negedge wr_clk); tb_wr_rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge wr_clk);
      if (done !== 1'b0 || rd_en !== 1'b0) done_seen = 1'b1;
    end
    total++;
    if (done_seen) begin
      bad++;
      $display("FAIL mid_reset_no_done: activity after abort, got %b want 0", done_seen);
    end
    run_sweep("after_reset", -1, -1, -1);
    total++;
    if (pass !== 1'b1 || err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL after_reset_result: pass=%b err=%0d want 1/0", pass, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_single_fault();
    test_saturation();
    test_start_rules();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
